pix_frame_reader: RTL and testbench
===================================

Name: pix_frame_reader

Overview:
- Read-side consumer for one pixel frame carried over the pixel AFIFO, running in the 120 MHz control domain.
- On `start` it requests a FIFO reset and waits for reset completion. It then drains exactly PIXEL_COUNT words through the `r_ready`/`r_trigger` handshake.
- Each word is checked against the descending test pattern from the pixel-side writer (PIXEL_COUNT-1 down to 0).
- After the frame it watches a tail window for unexpected extra words and reports pass/fail status.

Parameters:
- W, 16, FIFO data width.
- PIXEL_COUNT, 2304*1296, words per frame; must be ≥1.
- TAIL_CYCLES, 16, length of the post-frame extra-word watch window in clk cycles; must be ≥1.
- CNT_W, `RegWidth(PIXEL_COUNT-1)`, pixel counter width (derived, not overridden).

Ports:
- clk  in  1  control clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a capture.
- fifo_rst_req  out  1  toggle; each edge requests one FIFO reset.
- fifo_rst_done  in  1  single-cycle pulse, already synchronised to clk; FIFO reset complete.
- r_ready  in  1  FIFO has a word on `r_data`.
- r_trigger  out  1  read request; a word is consumed on a cycle where `r_trigger && r_ready`.
- r_data  in  W  FIFO read data.
- busy  out  1  high in any state except Idle/Done.
- done  out  1  single-cycle pulse on entry to Done.
- pass  out  1  valid from `done` until next `start`: no mismatch and no extra word.
- err_mismatch  out  1  sticky per capture.
- err_extra  out  1  sticky per capture.
- mismatch_count  out  CNT_W+1  count of mismatching words; saturates at all-ones.
- first_bad_index  out  CNT_W  expected value (counter) of the first mismatch.
- first_bad_data  out  W  `r_data` of the first mismatch.

Behaviour:
- Reset values (`rst_n` low, asynchronous): state Idle, all outputs 0, counters 0.
- Asserting `rst_n` low mid-capture aborts immediately with no `done` pulse. `fifo_rst_req` also returns to 0; the FIFO side tolerates this because it is edge-detected.
- States:
  - Idle/Done: `start` → Reset. On that transition clear all error and status outputs and `mismatch_count`.
  - Reset (1 cycle): toggle `fifo_rst_req` → WaitRst.
  - WaitRst: on `fifo_rst_done` → Read; load pix_cnt = PIXEL_COUNT-1. Any `r_ready` seen here is ignored; it is stale data from the previous session.
  - Read: `r_trigger` = 1 every cycle. On each handshake:
    - compare `r_data` against expected = `{zero-extend}` of pix_cnt, truncated/padded to W;
    - on mismatch, increment `mismatch_count` (saturating) and set `err_mismatch`;
    - if this is the first mismatch, capture `first_bad_index` = pix_cnt and `first_bad_data` = `r_data`;
    - if pix_cnt == 0: deassert `r_trigger` in the same clock edge's update, load tail_cnt = TAIL_CYCLES-1, go to Tail;
    - otherwise pix_cnt -= 1.
  - Tail: `r_trigger` = 0. If `r_ready` is seen in any cycle, set `err_extra`. When tail_cnt == 0 → Done, else tail_cnt -= 1.
  - Done: pulse `done` for one cycle; `pass` = !`err_mismatch` && !`err_extra`.
- `start` in Reset/WaitRst/Read/Tail is ignored (no restart).
- `start` coincident with `done` entry is also ignored: Done is entered first and the next `start` is honoured.
- Throughput: one word per cycle while `r_ready` is held.
- `r_ready` low in Read: wait indefinitely. There is no timeout.
- PIXEL_COUNT = 1: Read lasts until one handshake, then goes straight to Tail.
- Handshake on the cycle `r_trigger` first rises: that word is counted.
- Width rule: expected value is the low W bits of pix_cnt. If CNT_W > W, values alias modulo 2^W, matching the writer's truncation.

Decomposition:
- Shared package entries:
  - state encoding localparams (Idle=0, Reset, WaitRst, Read, Tail, Done);
  - the test-pattern function expected(idx) = idx[W-1:0], shared with the pixel-side writer so both ends stay identical.
- One natural sub-module: `pix_frame_checker`. Pure sequential compare, counting mismatches, saturating the count and latching the first bad index/data. Inputs are valid, data and expected; clear comes from the FSM.
- The FSM remains in `pix_frame_reader`.

Test Plan:
- Clean frame (PIXEL_COUNT=8, TAIL_CYCLES=4): FIFO model supplies 7..0 with `r_ready` always high → `fifo_rst_req` toggles once; exactly 8 handshakes; `done` after 8+4 cycles past the first handshake plus Done entry; `pass`=1; `mismatch_count`=0.
- Throttled frame: `r_ready` toggles 1,0,1,0 with data 7..0 → same result, `pass`=1, 8 handshakes total, `r_trigger` never low during Read.
- Corrupt word: word for index 5 replaced with 0x00AA, and index 2 with 0x0001 → `err_mismatch`=1, `mismatch_count`=2, `first_bad_index`=5, `first_bad_data`=0x00AA, `pass`=0.
- Extra word: 9th word presented 2 cycles into Tail → `err_extra`=1, `pass`=0, no 9th handshake (`r_trigger`=0).
- Stale data: `r_ready` high with junk during WaitRst before `fifo_rst_done` → no handshake, no error; frame then passes.
- Reset/restart: `rst_n` low mid-Read at index 3 → all outputs 0 asynchronously, no `done`. `start` during Read is ignored; a second `start` after `done` runs a full new capture with status cleared.

Source files
------------

// File: rtl/pix_frame_reader_pkg.sv
// Shared definitions for the pixel frame reader: FSM state encoding,
// counter-width helper and the frame test pattern used by both FIFO ends.
package pix_frame_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_WAITRST = 3'd2,
        ST_READ    = 3'd3,
        ST_TAIL    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Bits needed to hold max_val (never less than 1).
    function automatic int reg_width(input int max_val);
        int w;
        w = 1;
        while (w < 31 && (1 << w) <= max_val) w++;
        return w;
    endfunction

    // Descending test pattern: word value is the pixel index itself. The
    // caller keeps the low W bits, so wide counters alias modulo 2^W exactly
    // as the writer's truncation does.
    function automatic logic [31:0] expected(input logic [31:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/pix_frame_reader_checker.sv
// Per-word compare against the expected pattern; counts mismatches with
// saturation and latches index/data of the first bad word of a capture.
module pix_frame_checker
    import pix_frame_reader_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld,
    input  logic [W-1:0]     data,
    input  logic [W-1:0]     exp_data,
    input  logic [CNT_W-1:0] idx,
    output logic             err_mismatch,
    output logic [CNT_W:0]   mismatch_count,
    output logic [CNT_W-1:0] first_bad_index,
    output logic [W-1:0]     first_bad_data
);

    // Compare each consumed word; clear wipes the status for a new capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mismatch    <= 1'b0;
            mismatch_count  <= '0;
            first_bad_index <= '0;
            first_bad_data  <= '0;
        end else if (clr) begin
            err_mismatch    <= 1'b0;
            mismatch_count  <= '0;
            first_bad_index <= '0;
            first_bad_data  <= '0;
        end else if (vld && (data != exp_data)) begin
            err_mismatch <= 1'b1;
            if (mismatch_count != '1)
                mismatch_count <= mismatch_count + 1'b1;
            if (!err_mismatch) begin
                first_bad_index <= idx;
                first_bad_data  <= data;
            end
        end
    end

endmodule

// File: rtl/pix_frame_reader.sv
// Control-domain consumer of one pixel frame from the pixel AFIFO: resets the
// FIFO, drains PIXEL_COUNT words checking the descending pattern, then
// watches a short tail window for stray extra words.
module pix_frame_reader
    import pix_frame_reader_pkg::*;
#(
    parameter int W           = 16,
    parameter int PIXEL_COUNT = 2304 * 1296,
    parameter int TAIL_CYCLES = 16,
    localparam int CNT_W      = reg_width(PIXEL_COUNT - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             fifo_rst_req,
    input  logic             fifo_rst_done,
    input  logic             r_ready,
    output logic             r_trigger,
    input  logic [W-1:0]     r_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_mismatch,
    output logic             err_extra,
    output logic [CNT_W:0]   mismatch_count,
    output logic [CNT_W-1:0] first_bad_index,
    output logic [W-1:0]     first_bad_data
);

    localparam int                TAIL_W    = reg_width(TAIL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(PIXEL_COUNT - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    pix_cnt;
    logic [TAIL_W-1:0]   tail_cnt;
    logic [W-1:0]        exp_word;
    logic                hs;
    logic                clr;

    // A word is consumed only while actually reading; r_ready elsewhere is
    // stale or unexpected and must not reach the checker.
    assign hs       = (state == ST_READ) && r_trigger && r_ready;
    assign clr      = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign exp_word = W'(expected(32'(pix_cnt)));

    pix_frame_checker #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr             (clr),
        .vld             (hs),
        .data            (r_data),
        .exp_data        (exp_word),
        .idx             (pix_cnt),
        .err_mismatch    (err_mismatch),
        .mismatch_count  (mismatch_count),
        .first_bad_index (first_bad_index),
        .first_bad_data  (first_bad_data)
    );

    // Capture sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pix_cnt      <= '0;
            tail_cnt     <= '0;
            fifo_rst_req <= 1'b0;
            r_trigger    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_extra    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RESET;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_extra <= 1'b0;
                    end
                end
                ST_RESET: begin
                    // Edge-signalled request: the FIFO side detects the toggle.
                    fifo_rst_req <= ~fifo_rst_req;
                    state        <= ST_WAITRST;
                end
                ST_WAITRST: begin
                    if (fifo_rst_done) begin
                        pix_cnt   <= PIX_LAST;
                        r_trigger <= 1'b1;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (hs) begin
                        if (pix_cnt == '0) begin
                            r_trigger <= 1'b0;
                            tail_cnt  <= TAIL_LAST;
                            state     <= ST_TAIL;
                        end else begin
                            pix_cnt <= pix_cnt - 1'b1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (r_ready)
                        err_extra <= 1'b1;
                    if (tail_cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        // Fold in a stray word seen on this very last cycle.
                        pass  <= !err_mismatch && !err_extra && !r_ready;
                    end else begin
                        tail_cnt <= tail_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pix_frame_reader.sv
// Directed bench for pix_frame_reader with an 8-word frame and 4-cycle tail.
module tb_pix_frame_reader;

    localparam int W     = 16;
    localparam int PC    = 8;
    localparam int TC    = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             fifo_rst_done = 1'b0;
    logic             r_ready = 1'b0;
    logic [W-1:0]     r_data = '0;
    logic             fifo_rst_req, r_trigger, busy, done, pass;
    logic             err_mismatch, err_extra;
    logic [CNT_W:0]   mismatch_count;
    logic [CNT_W-1:0] first_bad_index;
    logic [W-1:0]     first_bad_data;

    pix_frame_reader #(
        .W           (W),
        .PIXEL_COUNT (PC),
        .TAIL_CYCLES (TC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .fifo_rst_req    (fifo_rst_req),
        .fifo_rst_done   (fifo_rst_done),
        .r_ready         (r_ready),
        .r_trigger       (r_trigger),
        .r_data          (r_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_mismatch    (err_mismatch),
        .err_extra       (err_extra),
        .mismatch_count  (mismatch_count),
        .first_bad_index (first_bad_index),
        .first_bad_data  (first_bad_data)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: presents words at negedge, counts handshakes it will see.
    bit           fm_en = 1'b0;
    bit           fm_throttle = 1'b0;
    bit           fm_phase = 1'b0;
    int           fm_idx = 0;
    int           hs_cnt = 0;
    int           trig_low = 0;
    int           t_first = 0;
    logic [W-1:0] fm_words [PC];

    always @(negedge clk) begin
        if (fm_en) begin
            fm_phase = !fm_phase;
            if (fm_idx > 0 && fm_idx < PC && !r_trigger) trig_low++;
            if (fm_idx < PC && (!fm_throttle || fm_phase)) begin
                r_ready = 1'b1;
                r_data  = fm_words[fm_idx];
            end else begin
                r_ready = 1'b0;
                r_data  = '0;
            end
            if (r_trigger && r_ready) begin
                fm_idx++;
                hs_cnt++;
                if (hs_cnt == 1) t_first = cyc;
            end
        end
    end

    logic prev_req = 1'b0;
    int   tgl_cnt = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (fifo_rst_req !== prev_req) tgl_cnt++;
        prev_req = fifo_rst_req;
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Start a capture and answer its FIFO reset request; optionally hold
    // stale junk on the read port while the reset is outstanding.
    task automatic begin_frame(input bit stale);
        int t0;
        bit seen;
        fm_en    = 1'b0;
        r_ready  = stale;
        r_data   = stale ? 16'hBEEF : 16'h0000;
        trig_low = 0;
        fm_idx   = 0;
        hs_cnt   = 0;
        fm_phase = 1'b0;
        t0       = tgl_cnt;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (tgl_cnt != t0) seen = 1'b1;
        end
        chk("rst_req_toggle_seen", 32'(seen), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_trigger_in_waitrst", 32'(r_trigger), 0);
        end
        fifo_rst_done = 1'b1;
        r_ready       = 1'b0;
        r_data        = '0;
        fm_en         = 1'b1;
        tick();
        fifo_rst_done = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int t_done);
        seen   = 1'b0;
        t_done = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) begin
                seen   = 1'b1;
                t_done = cyc;
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_hs(input int n);
        for (int i = 0; i < 60 && hs_cnt < n; i++) tick();
        chk("handshake_count_reached", 32'(hs_cnt), 32'(n));
    endtask

    task automatic load_clean();
        for (int p = 0; p < PC; p++) fm_words[p] = W'(PC - 1 - p);
    endtask

    typedef struct {
        bit          thr;
        int          pa;
        logic [15:0] va;
        int          pb;
        logic [15:0] vb;
        bit          e_pass;
        int          e_mcnt;
        int          e_fbi;
        int          e_fbd;
    } vec_t;

    vec_t vt [5];

    initial begin
        bit seen;
        int t_done, t0, d0;

        vt[0] = '{0, -1, 16'h0000, -1, 16'h0000, 1, 0, 0, 16'h0000};
        vt[1] = '{0,  2, 16'h00AA,  5, 16'h0001, 0, 2, 5, 16'h00AA};
        vt[2] = '{1, -1, 16'h0000, -1, 16'h0000, 1, 0, 0, 16'h0000};
        vt[3] = '{1,  0, 16'h1234, -1, 16'h0000, 0, 1, 7, 16'h1234};
        vt[4] = '{0, -1, 16'h0000, -1, 16'h0000, 1, 0, 0, 16'h0000};

        // Reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_trigger", 32'(r_trigger), 0);
        chk("rst_fifo_req", 32'(fifo_rst_req), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_mcnt", 32'(mismatch_count), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            load_clean();
            if (vt[v].pa >= 0) fm_words[vt[v].pa] = vt[v].va;
            if (vt[v].pb >= 0) fm_words[vt[v].pb] = vt[v].vb;
            fm_throttle = vt[v].thr;
            t0 = tgl_cnt;
            begin_frame(1'b0);
            wait_done(seen, t_done);
            chk("done_seen", 32'(seen), 1);
            chk("pass", 32'(pass), 32'(vt[v].e_pass));
            chk("err_mismatch", 32'(err_mismatch), 32'(vt[v].e_mcnt != 0));
            chk("err_extra", 32'(err_extra), 0);
            chk("mismatch_count", 32'(mismatch_count), 32'(vt[v].e_mcnt));
            chk("first_bad_index", 32'(first_bad_index), 32'(vt[v].e_fbi));
            chk("first_bad_data", 32'(first_bad_data), 32'(vt[v].e_fbd));
            chk("handshakes", 32'(hs_cnt), PC);
            chk("rst_req_toggles", 32'(tgl_cnt - t0), 1);
            chk("trigger_low_in_read", 32'(trig_low), 0);
            chk("busy_at_done", 32'(busy), 0);
            if (!vt[v].thr) chk("done_latency", 32'(t_done - t_first), PC + TC);
            tick();
            chk("done_one_cycle", 32'(done), 0);
        end
        fm_throttle = 1'b0;

        // Extra word two cycles into the tail window
        load_clean();
        begin_frame(1'b0);
        wait_hs(PC);
        fm_en = 1'b0;
        tick();
        r_ready = 1'b0;
        chk("extra_trig_tail1", 32'(r_trigger), 0);
        tick();
        r_ready = 1'b1;
        r_data  = 16'hFFFF;
        chk("extra_trig_tail2", 32'(r_trigger), 0);
        tick();
        r_ready = 1'b0;
        r_data  = '0;
        wait_done(seen, t_done);
        chk("extra_done_seen", 32'(seen), 1);
        chk("extra_err_extra", 32'(err_extra), 1);
        chk("extra_pass", 32'(pass), 0);
        chk("extra_err_mismatch", 32'(err_mismatch), 0);
        chk("extra_handshakes", 32'(hs_cnt), PC);

        // Stale data held during the FIFO reset wait
        load_clean();
        begin_frame(1'b1);
        wait_done(seen, t_done);
        chk("stale_done_seen", 32'(seen), 1);
        chk("stale_pass", 32'(pass), 1);
        chk("stale_err_extra", 32'(err_extra), 0);
        chk("stale_err_mismatch", 32'(err_mismatch), 0);
        chk("stale_handshakes", 32'(hs_cnt), PC);

        // start during Read is ignored
        t0 = tgl_cnt;
        begin_frame(1'b0);
        wait_hs(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(seen, t_done);
        chk("ign_done_seen", 32'(seen), 1);
        chk("ign_toggles", 32'(tgl_cnt - t0), 1);
        chk("ign_handshakes", 32'(hs_cnt), PC);
        chk("ign_pass", 32'(pass), 1);
        tick();
        tick();
        chk("ign_no_restart", 32'(busy), 0);

        // Asynchronous reset mid-Read, with index 3 next to be read
        load_clean();
        fm_words[0] = 16'h0F0F;
        begin_frame(1'b0);
        wait_hs(4);
        chk("mid_err_mismatch_pre", 32'(err_mismatch), 1);
        chk("mid_busy_pre", 32'(busy), 1);
        d0    = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_trigger", 32'(r_trigger), 0);
        chk("mid_fifo_req", 32'(fifo_rst_req), 0);
        chk("mid_err_mismatch", 32'(err_mismatch), 0);
        chk("mid_mcnt", 32'(mismatch_count), 0);
        chk("mid_fbi", 32'(first_bad_index), 0);
        chk("mid_fbd", 32'(first_bad_data), 0);
        chk("mid_pass", 32'(pass), 0);
        fm_en   = 1'b0;
        r_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_no_done", 32'(done_cnt - d0), 0);

        // Fresh capture after the abort
        load_clean();
        begin_frame(1'b0);
        wait_done(seen, t_done);
        chk("after_done_seen", 32'(seen), 1);
        chk("after_pass", 32'(pass), 1);
        chk("after_mcnt", 32'(mismatch_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
